fibo_blink_monitor: RTL and testbench
=====================================

// Module: fibo_blink_monitor
// PURPOSE
//   Receive-side checker for the Fibonacci blink output. Samples one blink line and
//   measures each high pulse in prescaled ticks. Compares every pulse against the
//   expected Fibonacci term (1,1,2,3,5,...). Reports period, match, lock and error
//   count. Used on-chip for loopback self-test, and on a companion board as a decoder.
// PARAMETERS
//   TICK_DIV       1000  clk cycles per measurement tick (>=2)
//   CNT_W          16    width of tick counter, period output and Fibonacci terms
//   SEQ_LEN        12    terms per sequence before expectation wraps to 1,1
//   LOCK_N         3     consecutive matches required to assert locked
//   TIMEOUT_TICKS  64    low-time limit in ticks (only with FIBO_MON_TIMEOUT_EN)
// PORTS
//   clk         in   1      system clock
//   rst         in   1      synchronous reset, active-high
//   en          in   1      monitor enable
//   blink_in    in   1      asynchronous blink line
//   period      out  CNT_W  last measured high time, in ticks
//   period_vld  out  1      one-cycle pulse: period/match updated
//   match       out  1      last period equalled the expected term
//   locked      out  1      LOCK_N consecutive matches seen, no error since
//   term_idx    out  4      index of the next expected term (0..SEQ_LEN-1)
//   err_count   out  8      saturating mismatch count
//   timeout     out  1      one-cycle pulse on low-time timeout (0 if feature absent)
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; expected pair (a,b)=(1,1); sync flops 0.
// - blink_in passes through a 2-FF synchronizer to blink_s; edges use a third flop.
// - FSM states:
//   - IDLE: entered on en=0. Clears tick counter, prescaler and locked.
//     Keeps err_count, period and the expectation. Goes to WAIT_RISE when en=1.
//   - WAIT_RISE: waits for a rising edge of blink_s; a pulse already high at
//     enable is ignored. On the rising edge: prescaler=0, ticks=0, go to HIGH.
//   - HIGH: prescaler counts 0..TICK_DIV-1; ticks++ on each wrap. ticks saturates
//     at 2^CNT_W-1 and sets ovf. A falling edge of blink_s goes to REPORT.
//   - REPORT (1 cycle): period<=ticks and period_vld=1.
//     match<=(ticks==a)&&!ovf. Next state is WAIT_RISE, or HIGH if a rising
//     edge is seen in this same cycle.
// - Measured value is floor(high_cycles/TICK_DIV).
// - Latency: period_vld rises 4 clk after blink_in falls
//   (2 sync + 1 edge + 1 REPORT register).
// - On match: (a,b)<=(b,a+b) and term_idx++. The consecutive-match count
//   increments; locked=1 once it reaches LOCK_N.
// - On mismatch: (a,b)<=(1,1), term_idx<=0, match count<=0, locked<=0, and
//   err_count++ (saturates at 255).
// - Wrap: term_idx reaching SEQ_LEN, or a+b overflowing CNT_W, resets (a,b)=(1,1)
//   and term_idx=0 after the match. This is not an error and lock is kept.
// - rst mid-pulse aborts the measurement; no period_vld is emitted.
// - en dropping mid-pulse goes to IDLE; no report is made for that pulse.
// CONFIGURATION
// - FIBO_MON_TIMEOUT_EN defined: WAIT_RISE also counts low-time ticks.
//   - Limit reached when low time reaches TIMEOUT_TICKS.
//   - On the limit: timeout pulses 1 cycle, locked<=0, (a,b)<=(1,1),
//     term_idx<=0, and the low counter restarts.
//   - err_count is unchanged by a timeout.
// - FIBO_MON_TIMEOUT_EN undefined: no low counter is built; timeout is tied 0.
// TESTING (TICK_DIV=4 unless noted)
// 1. rst 2 cycles, then hold en=0: all outputs 0, term_idx=0.
// 2. en=1; drive high pulses of 4,4,8,12,20 clk with gaps of 8 clk.
//    -> periods 1,1,2,3,5, all match=1; locked after 3rd; term_idx=5.
// 3. Locked, then drive a 12 clk pulse where 8 is expected.
//    -> period=3, match=0, locked=0, err_count=1, term_idx=0.
// 4. blink_in already high when en rises, then falls -> no period_vld.
//    Next full 4 clk pulse -> period=1, match=1.
// 5. CNT_W=4: high for 80 clk -> period=15 (saturated), match=0, err_count++.
// 6. FIBO_MON_TIMEOUT_EN, TIMEOUT_TICKS=8: lock, then hold low 32 clk.
//    -> timeout pulse, locked=0, term_idx=0, err_count unchanged.

Source files
------------

// File: rtl/fibo_blink_monitor.sv
// Fibonacci blink receive-side checker: measures high pulses in prescaled ticks and
// compares each against the expected term. Optional low-time timeout: FIBO_MON_TIMEOUT_EN.
module fibo_blink_monitor #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SEQ_LEN       = 12,
  parameter int unsigned LOCK_N        = 3,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             match,
  output logic             locked,
  output logic [3:0]       term_idx,
  output logic [7:0]       err_count,
  output logic             timeout
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MW = $clog2(LOCK_N + 1);

  if (TICK_DIV < 2 || TIMEOUT_TICKS < 1) begin : g_bad_param
    $error("fibo_blink_monitor: TICK_DIV must be >= 2 and TIMEOUT_TICKS >= 1");
  end

  typedef enum logic [1:0] {StIdle, StWaitRise, StHigh, StReport} state_e;

  state_e           state_q;
  logic             blink_meta_q, blink_s_q, blink_d_q;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] ticks_q, a_q, b_q;
  logic             ovf_q;
  logic [MW-1:0]    mcnt_q;

  logic             rise, fall, presc_wrap, is_match, seq_wrap;
  logic [CNT_W:0]   sum;
  logic [MW-1:0]    mcnt_inc;

  always_comb begin
    rise       = blink_s_q & ~blink_d_q;
    fall       = ~blink_s_q & blink_d_q;
    presc_wrap = (presc_q == PW'(TICK_DIV - 1));
    is_match   = (ticks_q == a_q) && !ovf_q;
    sum        = {1'b0, a_q} + {1'b0, b_q};
    // Restart the sequence after the last term or when the next term would not fit.
    seq_wrap   = (term_idx == 4'(SEQ_LEN - 1)) || sum[CNT_W];
    mcnt_inc   = (mcnt_q == MW'(LOCK_N)) ? mcnt_q : mcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      blink_meta_q <= 1'b0;
      blink_s_q    <= 1'b0;
      blink_d_q    <= 1'b0;
      presc_q      <= '0;
      ticks_q      <= '0;
      ovf_q        <= 1'b0;
      a_q          <= CNT_W'(1);
      b_q          <= CNT_W'(1);
      mcnt_q       <= '0;
      period       <= '0;
      period_vld   <= 1'b0;
      match        <= 1'b0;
      locked       <= 1'b0;
      term_idx     <= '0;
      err_count    <= '0;
      timeout      <= 1'b0;
    end else begin
      blink_meta_q <= blink_in;
      blink_s_q    <= blink_meta_q;
      blink_d_q    <= blink_s_q;
      period_vld   <= 1'b0;
      timeout      <= 1'b0;
      if (!en) begin
        // Dropping enable abandons any pulse in flight without reporting it.
        state_q <= StIdle;
        presc_q <= '0;
        ticks_q <= '0;
        ovf_q   <= 1'b0;
        mcnt_q  <= '0;
        locked  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StWaitRise;
          StWaitRise: begin
            if (rise) begin
              presc_q <= '0;
              ticks_q <= '0;
              ovf_q   <= 1'b0;
              state_q <= StHigh;
            end
`ifdef FIBO_MON_TIMEOUT_EN
            else if (presc_wrap) begin
              presc_q <= '0;
              if (ticks_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                ticks_q  <= '0;
                timeout  <= 1'b1;
                locked   <= 1'b0;
                mcnt_q   <= '0;
                a_q      <= CNT_W'(1);
                b_q      <= CNT_W'(1);
                term_idx <= '0;
              end else begin
                ticks_q <= ticks_q + 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
`endif
          end
          StHigh: begin
            if (presc_wrap) begin
              presc_q <= '0;
              if (ticks_q == '1) ovf_q <= 1'b1;
              else ticks_q <= ticks_q + 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
            if (fall) state_q <= StReport;
          end
          StReport: begin
            period     <= ticks_q;
            period_vld <= 1'b1;
            match      <= is_match;
            if (is_match) begin
              mcnt_q <= mcnt_inc;
              locked <= (mcnt_inc == MW'(LOCK_N));
              if (seq_wrap) begin
                a_q      <= CNT_W'(1);
                b_q      <= CNT_W'(1);
                term_idx <= '0;
              end else begin
                a_q      <= b_q;
                b_q      <= sum[CNT_W-1:0];
                term_idx <= term_idx + 4'd1;
              end
            end else begin
              mcnt_q   <= '0;
              locked   <= 1'b0;
              a_q      <= CNT_W'(1);
              b_q      <= CNT_W'(1);
              term_idx <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            presc_q <= '0;
            ticks_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= rise ? StHigh : StWaitRise;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibo_blink_monitor.sv
// Directed bench for fibo_blink_monitor at TICK_DIV=4, plus a CNT_W=4 instance for saturation.
module tb_fibo_blink_monitor;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst, en, blink, en4, blink4;
  logic [15:0] period;
  logic        period_vld, match, locked, timeout;
  logic [3:0]  term_idx;
  logic [7:0]  err_count;
  logic [3:0]  period4;
  logic        period_vld4, match4, locked4, timeout4;
  logic [3:0]  term_idx4;
  logic [7:0]  err_count4;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0, vld_cnt4 = 0, to_cnt = 0;

  always #5 clk = ~clk;

  fibo_blink_monitor #(
    .TICK_DIV(TD), .CNT_W(16), .SEQ_LEN(12), .LOCK_N(3), .TIMEOUT_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .blink_in(blink), .period(period),
    .period_vld(period_vld), .match(match), .locked(locked), .term_idx(term_idx),
    .err_count(err_count), .timeout(timeout)
  );

  fibo_blink_monitor #(
    .TICK_DIV(TD), .CNT_W(4), .SEQ_LEN(12), .LOCK_N(3), .TIMEOUT_TICKS(8)
  ) dut4 (
    .clk(clk), .rst(rst), .en(en4), .blink_in(blink4), .period(period4),
    .period_vld(period_vld4), .match(match4), .locked(locked4), .term_idx(term_idx4),
    .err_count(err_count4), .timeout(timeout4)
  );

  always @(posedge clk) begin
    if (period_vld) vld_cnt <= vld_cnt + 1;
    if (period_vld4) vld_cnt4 <= vld_cnt4 + 1;
    if (timeout) to_cnt <= to_cnt + 1;
  end

  typedef struct {
    int hi;
    int per;
    int mat;
    int lck;
    int idx;
    int err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one high pulse then an 8-clk gap; reports whether a single period_vld was seen.
  task automatic pulse(input int hi, output int nvld);
    int base;
    blink = 1'b1;
    tick(hi);
    blink = 1'b0;
    base = vld_cnt;
    tick(8);
    nvld = vld_cnt - base;
  endtask

  task automatic chk_state(input string name, input int per, input int mat, input int lck,
                           input int idx, input int err);
    chk({name, "_period"}, period, per);
    chk({name, "_match"}, match, mat);
    chk({name, "_locked"}, locked, lck);
    chk({name, "_term_idx"}, term_idx, idx);
    chk({name, "_err_count"}, err_count, err);
  endtask

  initial begin
    vec_t vecs[7];
    int   nvld, base, a, b, s;

    vecs[0] = '{hi: 4,  per: 1, mat: 1, lck: 0, idx: 1, err: 0};
    vecs[1] = '{hi: 4,  per: 1, mat: 1, lck: 0, idx: 2, err: 0};
    vecs[2] = '{hi: 8,  per: 2, mat: 1, lck: 1, idx: 3, err: 0};
    vecs[3] = '{hi: 12, per: 3, mat: 1, lck: 1, idx: 4, err: 0};
    vecs[4] = '{hi: 20, per: 5, mat: 1, lck: 1, idx: 5, err: 0};
    vecs[5] = '{hi: 12, per: 3, mat: 0, lck: 0, idx: 0, err: 1};
    vecs[6] = '{hi: 4,  per: 1, mat: 1, lck: 0, idx: 1, err: 1};

    rst = 1'b1; en = 1'b0; blink = 1'b0; en4 = 1'b0; blink4 = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("reset_vld", period_vld, 0);
    chk("reset_timeout", timeout, 0);
    chk_state("reset", 0, 0, 0, 0, 0);
    tick(5);
    chk_state("idle_en0", 0, 0, 0, 0, 0);

    en = 1'b1;
    tick(2);
    for (int i = 0; i < 7; i++) begin
      pulse(vecs[i].hi, nvld);
      chk($sformatf("vec%0d_vld", i), nvld, 1);
      chk_state($sformatf("vec%0d", i), vecs[i].per, vecs[i].mat, vecs[i].lck,
                vecs[i].idx, vecs[i].err);
    end

    // Pulse already high when enabled must not be reported.
    en = 1'b0;
    blink = 1'b1;
    tick(4);
    en = 1'b1;
    tick(5);
    blink = 1'b0;
    base = vld_cnt;
    tick(10);
    chk("pre_high_no_vld", vld_cnt - base, 0);
    pulse(4, nvld);
    chk("after_pre_high_vld", nvld, 1);
    chk("after_pre_high_period", period, 1);
    chk("after_pre_high_match", match, 1);
    chk("after_pre_high_idx", term_idx, 2);
    chk("after_pre_high_err", err_count, 1);

    // Reset in the middle of a pulse aborts it.
    blink = 1'b1;
    base = vld_cnt;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    blink = 1'b0;
    tick(10);
    chk("rst_mid_no_vld", vld_cnt - base, 0);
    chk_state("rst_mid", 0, 0, 0, 0, 0);

    // Full 12-term sequence then wrap back to the first term, lock kept.
    a = 1; b = 1;
    for (int k = 0; k < 12; k++) begin
      pulse(a * TD, nvld);
      chk($sformatf("seq%0d_vld", k), nvld, 1);
      chk($sformatf("seq%0d_period", k), period, a);
      chk($sformatf("seq%0d_match", k), match, 1);
      s = a + b; a = b; b = s;
    end
    chk("wrap_idx", term_idx, 0);
    chk("wrap_locked", locked, 1);
    pulse(TD, nvld);
    chk("post_wrap_period", period, 1);
    chk("post_wrap_match", match, 1);
    chk("post_wrap_idx", term_idx, 1);
    chk("post_wrap_locked", locked, 1);
    chk("post_wrap_err", err_count, 0);

    // Narrow counter saturates on an overlong pulse.
    en4 = 1'b1;
    tick(2);
    blink4 = 1'b1;
    tick(80);
    blink4 = 1'b0;
    tick(8);
    chk("sat_vld", vld_cnt4, 1);
    chk("sat_period", period4, 15);
    chk("sat_match", match4, 0);
    chk("sat_err", err_count4, 1);

`ifdef FIBO_MON_TIMEOUT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pulse(4, nvld);
    pulse(4, nvld);
    pulse(8, nvld);
    chk("to_pre_locked", locked, 1);
    base = to_cnt;
    for (int i = 0; i < 80 && to_cnt == base; i++) tick(1);
    chk("to_seen", to_cnt - base, 1);
    chk("to_locked", locked, 0);
    chk("to_idx", term_idx, 0);
    chk("to_err", err_count, 0);
`else
    chk("no_timeout_pulses", to_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
